// File: rtl/square_freq_counter.sv
// Square-channel period timer: 11-bit period register and down counter that
// produce the FCO carry level, the FLOAD step strobe and the ultrasonic MUTE flag.
module square_freq_counter #(
   parameter int PERIOD_BITS = 11,
   parameter int MUTE_LIMIT  = 8
) (
   input  logic                   CLK,
   input  logic                   RES,
   input  logic                   ACLK1,
   input  logic                   WR2,
   input  logic                   WR3,
   input  logic [7:0]             DB,
   output logic                   FCO,
   output logic                   FLOAD,
   output logic                   MUTE,
   output logic [PERIOD_BITS-1:0] PERIOD
);

   localparam logic [PERIOD_BITS-1:0] ONE      = PERIOD_BITS'(1);
   localparam logic [PERIOD_BITS-1:0] MUTE_VAL = PERIOD_BITS'(MUTE_LIMIT);

   logic [PERIOD_BITS-1:0] freq;
   logic [PERIOD_BITS-1:0] cnt;
   logic                   fco_q;
   logic                   fload_q;
   logic                   mute_q;

   // Upper data bits belong to the length counter, not this block.
   logic unused_db;
   assign unused_db = ^DB[7:PERIOD_BITS-8];

   // NOTE: all state uses non-blocking assignments, so the reload below reads
   // the pre-write freq even when a write lands in the same cycle.
   always_ff @(posedge CLK) begin
      if (RES) begin
         freq    <= '0;
         cnt     <= '0;
         fco_q   <= 1'b1;
         fload_q <= 1'b0;
         mute_q  <= 1'b1;
      end else begin
         if (WR2) freq[7:0]             <= DB;
         if (WR3) freq[PERIOD_BITS-1:8] <= DB[PERIOD_BITS-9:0];

         fload_q <= 1'b0;
         if (ACLK1) begin
            if (cnt == '0) begin
               cnt     <= freq;
               fco_q   <= (freq == '0);
               fload_q <= 1'b1;
            end else begin
               cnt   <= cnt - ONE;
               fco_q <= (cnt == ONE);
            end
         end

         mute_q <= (freq < MUTE_VAL);
      end
   end

   assign FCO    = fco_q;
   assign FLOAD  = fload_q;
   assign MUTE   = mute_q;
   assign PERIOD = freq;

endmodule

// File: tb/tb_square_freq_counter.sv
// Self-checking bench for square_freq_counter: a table of single-cycle vectors
// followed by hand-written sequences for collision, mute boundary and mid-count reset.
module tb_square_freq_counter;

   logic        CLK = 1'b0;
   logic        RES = 1'b1;
   logic        ACLK1 = 1'b0;
   logic        WR2 = 1'b0;
   logic        WR3 = 1'b0;
   logic [7:0]  DB = 8'h00;
   logic        FCO;
   logic        FLOAD;
   logic        MUTE;
   logic [10:0] PERIOD;

   int n_vec  = 0;
   int n_miss = 0;

   square_freq_counter #(.PERIOD_BITS(11), .MUTE_LIMIT(8)) dut (
      .CLK    (CLK),
      .RES    (RES),
      .ACLK1  (ACLK1),
      .WR2    (WR2),
      .WR3    (WR3),
      .DB     (DB),
      .FCO    (FCO),
      .FLOAD  (FLOAD),
      .MUTE   (MUTE),
      .PERIOD (PERIOD)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        res;
      logic        aclk;
      logic        wr2;
      logic        wr3;
      logic [7:0]  db;
      logic        fco;
      logic        fload;
      logic        mute;
      logic [10:0] period;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic res, input logic aclk, input logic wr2,
                               input logic wr3, input logic [7:0] db,
                               input logic fco, input logic fload, input logic mute,
                               input logic [10:0] period);
      vec_t v;
      v.res = res; v.aclk = aclk; v.wr2 = wr2; v.wr3 = wr3; v.db = db;
      v.fco = fco; v.fload = fload; v.mute = mute; v.period = period;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one CLK cycle of inputs, then return 1 time unit after the edge.
   task automatic drive(input logic res, input logic aclk, input logic wr2,
                        input logic wr3, input logic [7:0] db);
      RES = res; ACLK1 = aclk; WR2 = wr2; WR3 = wr3; DB = db;
      @(posedge CLK);
      #1;
      RES = 1'b0; ACLK1 = 1'b0; WR2 = 1'b0; WR3 = 1'b0; DB = 8'h00;
   endtask

   // One tick followed by an idle cycle; returns the outputs seen right after the tick.
   task automatic tick(output logic fload_seen, output logic fco_seen);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      fload_seen = FLOAD;
      fco_seen   = FCO;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Ticks until FLOAD is seen; returns the number of ticks taken (0 if bound expires).
   task automatic ticks_to_reload(input int bound, output int n);
      logic fl, fc;
      n = 0;
      for (int i = 1; i <= bound; i++) begin
         tick(fl, fc);
         if (fl) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      logic fl, fc;
      int   n;

      // Reset, register writes, then period N=2 with a tick every 6 CLK.
      add(1, 0, 0, 0, 8'h00, 1, 0, 1, 11'h000);
      add(1, 0, 0, 0, 8'h00, 1, 0, 1, 11'h000);
      add(0, 0, 0, 0, 8'h00, 1, 0, 1, 11'h000);
      add(0, 1, 0, 0, 8'h00, 1, 1, 1, 11'h000);
      add(0, 0, 0, 0, 8'h00, 1, 0, 1, 11'h000);
      add(0, 0, 1, 0, 8'h05, 1, 0, 1, 11'h005);
      add(0, 0, 0, 1, 8'hFB, 1, 0, 1, 11'h305);
      add(0, 0, 0, 0, 8'h00, 1, 0, 0, 11'h305);
      add(0, 0, 0, 1, 8'h00, 1, 0, 0, 11'h005);
      add(0, 0, 1, 0, 8'h02, 1, 0, 1, 11'h002);
      add(0, 0, 0, 0, 8'h00, 1, 0, 1, 11'h002);
      for (int t = 0; t < 6; t++) begin
         add(0, 1, 0, 0, 8'h00, (t % 3 == 2), (t % 3 == 0), 1, 11'h002);
         for (int k = 0; k < 5; k++)
            add(0, 0, 0, 0, 8'h00, (t % 3 == 2), 0, 1, 11'h002);
      end
      add(0, 0, 1, 0, 8'h04, 1, 0, 1, 11'h004);
      add(0, 0, 0, 0, 8'h00, 1, 0, 1, 11'h004);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].res, vecs[i].aclk, vecs[i].wr2, vecs[i].wr3, vecs[i].db);
         check($sformatf("vec%0d fco", i),    11'(FCO),   11'(vecs[i].fco));
         check($sformatf("vec%0d fload", i),  11'(FLOAD), 11'(vecs[i].fload));
         check($sformatf("vec%0d mute", i),   11'(MUTE),  11'(vecs[i].mute));
         check($sformatf("vec%0d period", i), PERIOD,     vecs[i].period);
      end

      // Collision: cnt=0, freq=4, write 9 on the same tick; reload takes 4.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h09);
      check("coll fload", 11'(FLOAD), 11'd1);
      check("coll fco", 11'(FCO), 11'd0);
      check("coll period", PERIOD, 11'h009);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      ticks_to_reload(30, n);
      check("coll old period ticks", 11'(n), 11'd5);
      ticks_to_reload(30, n);
      check("coll new period ticks", 11'(n), 11'd10);

      // Mute boundary at 7/8 and 0, including the 2-CLK latency.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h07);
      check("mute9 still", 11'(MUTE), 11'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("mute7", 11'(MUTE), 11'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h08);
      check("mute8 latency", 11'(MUTE), 11'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("mute8", 11'(MUTE), 11'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("mute0 latency", 11'(MUTE), 11'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("mute0", 11'(MUTE), 11'd1);
      ticks_to_reload(20, n);
      check("freq0 drain found reload", 11'(n != 0), 11'd1);
      for (int i = 0; i < 3; i++) begin
         tick(fl, fc);
         check($sformatf("freq0 tick%0d fload", i), 11'(fl), 11'd1);
         check($sformatf("freq0 tick%0d fco", i),   11'(fc), 11'd1);
      end

      // Reset mid-count: freq=0x7FF, run cnt down to 0x400, then reset.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
      check("max period", PERIOD, 11'h7FF);
      tick(fl, fc);
      check("max reload fload", 11'(fl), 11'd1);
      check("max reload fco", 11'(fc), 11'd0);
      for (int i = 0; i < 11'h3FF; i++) tick(fl, fc);
      check("midcount fco", 11'(FCO), 11'd0);
      check("midcount no fload", 11'(fl), 11'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
      check("rst fco", 11'(FCO), 11'd1);
      check("rst fload", 11'(FLOAD), 11'd0);
      check("rst period", PERIOD, 11'h000);
      check("rst mute", 11'(MUTE), 11'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick(fl, fc);
      check("post rst fload", 11'(fl), 11'd1);
      check("post rst fco", 11'(fc), 11'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/square_freq_counter.md
# square_freq_counter

Square-channel frequency (period) timer of the APU, directly upstream of the square duty unit. Holds the 11-bit period written through the register interface, down-counts it once per APU tick (`ACLK1`), and produces the carry level `FCO` and step strobe `FLOAD` that advance the duty counter. Also flags ultrasonic periods (`MUTE`) for the channel output stage.

## Interface
Parameters:
- `PERIOD_BITS`, 11: width of the period register and down counter; fixed at 11 for 2A03 compatibility.
- `MUTE_LIMIT`, 8: periods strictly below this value assert `MUTE`.

Ports:
- `CLK`  in  1  core clock; single clock domain.
- `RES`  in  1  reset, synchronous, active-high.
- `ACLK1`  in  1  APU tick enable; one-`CLK`-wide pulse, never on two consecutive `CLK` cycles.
- `WR2`  in  1  write strobe, period low byte; one `CLK` wide.
- `WR3`  in  1  write strobe, period high bits; one `CLK` wide.
- `DB`  in  8  data bus; valid in any cycle where `WR2` or `WR3` is high.
- `FCO`  out  1  counter-at-zero level, registered.
- `FLOAD`  out  1  step strobe, one `CLK` pulse per counter reload.
- `MUTE`  out  1  period below `MUTE_LIMIT`, registered.
- `PERIOD`  out  11  current period register, for sweep/debug.

## Operation
- State: `freq[10:0]` (period register), `cnt[10:0]` (down counter).
- `WR2`: `freq[7:0] <= DB[7:0]`. `WR3`: `freq[10:8] <= DB[2:0]`; `DB[7:3]` ignored here. `WR2` and `WR3` in the same cycle update both fields.
- Writes never touch `cnt`. A new period takes effect at the next reload.
- On `ACLK1` high:
  - If `cnt == 0`: `cnt <= freq` (the reload).
  - Else: `cnt <= cnt - 1`.
- Without `ACLK1`, `cnt` holds.
- Period: with stable `freq = N`, reloads occur every N+1 ticks.
- `freq = 0`: every tick is a reload. `FCO` stays 1 and `FLOAD` pulses on every tick.
- `FCO = (cnt == 0)`, driven from a register updated in the same cycle as `cnt`.
- `FLOAD` is registered and goes high for exactly one `CLK`, in the cycle after a tick that performed a reload.
- `MUTE = (freq < MUTE_LIMIT)`, registered one cycle after `freq` changes.
- Arithmetic is unsigned, 11 bits. The decrement never wraps, because 0 always reloads.
- Simultaneous write and reload in one `CLK`: the reload uses the old `freq`, and the written value lands in `freq`.
- `WR3` does not reset `cnt`. Duty-counter clearing on `WR3` belongs to the duty unit.

## Timing
- Reset (`RES` high at a `CLK` edge): `freq = 0`, `cnt = 0`, `FCO = 1`, `FLOAD = 0`, `MUTE = 1`, `PERIOD = 0`.
- `RES` overrides `ACLK1`, `WR2` and `WR3` in the same cycle.
- Reset mid-count: the state is discarded and the first tick after release reloads from `freq = 0` (or from the value written after release).
- Write to `PERIOD` visible: 1 `CLK`. Write to `MUTE` visible: 2 `CLK`.
- Tick to `cnt`/`FCO` update: 1 `CLK`. Reload tick to `FLOAD` high: 1 `CLK`; `FLOAD` is low again the following cycle.
- `FCO` is high throughout the interval from the tick that reaches 0 until the next tick.

## Test plan
- Reset behaviour: hold `RES` 2 cycles, then release. Required: `FCO=1`, `FLOAD=0`, `MUTE=1`, `PERIOD=0`; the first `ACLK1` gives a `FLOAD` pulse and `FCO` stays 1.
- Register writes: `WR2` with `DB=0x05`, then `WR3` with `DB=0xFB`. Required: `PERIOD=0x305`; `MUTE=0` two cycles after the `WR3`.
- Period N=2, `ACLK1` every 6 `CLK`:
  - After the first reload, `FLOAD` pulses on every 3rd tick.
  - `FCO` pattern per tick is 0,0,1 repeating.
  - Each `FLOAD` pulse is exactly 1 `CLK` wide.
- Collision: `cnt=0` with `freq=4`; `WR2 DB=0x09` in the same cycle as a tick. Required: `cnt=4` (old value), then the next reload period is 10 ticks.
- Mute boundary: `freq=7` gives `MUTE=1`; `freq=8` gives `MUTE=0`; `freq=0` gives `MUTE=1` with `FLOAD` on every tick.
- Reset mid-count: `freq=0x7FF`, `cnt≈0x400`, assert `RES` for 1 cycle. Required: `cnt=0`, `FCO=1`, `PERIOD=0`; the next tick produces `FLOAD`.
